// File: rtl/rm_pkg.sv
// rm_pkg: shared types, constants and config check for the rate-matcher bit selector
package rm_pkg;
  typedef enum logic [2:0] {IDLE, SETUP, MOD, RUN, DRAIN} state_t;
  localparam int NULL_BIT = 1;
  localparam int C = 32;
  function automatic logic cfg_ok(input int unsigned qm, e, ncb, kw, r, beat_w);
    return qm >= 1 && qm <= beat_w && e != 0 && (e % qm) == 0 && ncb >= 1 && ncb <= kw && r != 0;
  endfunction
endpackage

// File: rtl/rm_beat_packer.sv
// rm_beat_packer: packs selected bits into qm-bit beats held over a valid/ready handshake
module rm_beat_packer #(
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [3:0]        qm,
  input  logic              in_flight,
  input  logic              bit_valid,
  input  logic              bit_in,
  input  logic              out_ready,
  output logic              out_valid,
  output logic [BEAT_W-1:0] out_bits,
  output logic              room
);
  localparam int P_W = $clog2(BEAT_W + 1);
  logic [P_W-1:0]    fill;
  logic [BEAT_W-1:0] sh;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      out_valid <= 1'b0;
      fill <= '0;
      sh <= '0;
    end else if (clr || (out_valid && out_ready)) begin
      out_valid <= 1'b0;
      fill <= '0;
      sh <= '0;
    end else if (bit_valid) begin
      sh <= sh | (BEAT_W'(bit_in) << fill);
      fill <= fill + 1'b1;
      out_valid <= int'(fill) + 1 == int'(qm);
    end
  assign out_bits = out_valid ? sh : '0;
  assign room = !out_valid && int'(fill) + int'(in_flight) < int'(qm);
endmodule

// File: rtl/rm_bit_selector.sv
// rm_bit_selector: k0/Ncb circular-buffer bit selection with null skipping, emitting qm-bit beats
module rm_bit_selector
  import rm_pkg::*;
#(
  parameter int R_W    = 7,
  parameter int ADDR_W = 13,
  parameter int E_W    = 16,
  parameter int BEAT_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  output logic              ready,
  input  logic [1:0]        rv_idx,
  input  logic [R_W-1:0]    R,
  input  logic [ADDR_W-1:0] Kw,
  input  logic [ADDR_W-1:0] Ncb,
  input  logic [E_W-1:0]    E,
  input  logic [3:0]        qm,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [1:0]        rd_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BEAT_W-1:0] out_bits,
  output logic              out_last,
  output logic              done,
  output logic              err
);
  localparam int N_W = ADDR_W - 2;
  localparam int K_W = R_W + ADDR_W;
  state_t            state, nxt;
  logic [1:0]        cfg_rv;
  logic [R_W-1:0]    cfg_r;
  logic [ADDR_W-1:0] cfg_ncb, rem, ptr, null_cnt;
  logic [E_W-1:0]    cfg_e, cnt;
  logic [3:0]        cfg_q;
  logic [N_W-1:0]    n;
  logic [K_W-1:0]    k0, k0_calc, step;
  logic              in_flight, err_q, idle, go, cfg_good, last_rem, is_null, got_bit, abort, hs, room;
  assign idle = state == IDLE || state == DRAIN;
  assign go = idle && start;
  assign cfg_good = cfg_ok(32'(qm), 32'(E), 32'(Ncb), 32'(Kw), 32'(R), BEAT_W);
  assign step = K_W'(cfg_r) * K_W'(C / 4);
  assign last_rem = K_W'(rem) <= step;
  // n+1 because this is the cycle that performs the final subtraction
  assign k0_calc = K_W'({cfg_r, 1'b0}) * (K_W'(n) + K_W'(1)) * K_W'(cfg_rv) + K_W'({cfg_r, 1'b0});
  assign is_null = in_flight && rd_data[NULL_BIT];
  assign got_bit = in_flight && !rd_data[NULL_BIT];
  assign abort = state == RUN && is_null && null_cnt + 1'b1 == cfg_ncb;
  assign hs = out_valid && out_ready;
  assign out_last = out_valid && cnt + E_W'(cfg_q) == cfg_e;
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    case (state)
      IDLE, DRAIN: nxt = go && cfg_good ? SETUP : IDLE;
      SETUP:       nxt = last_rem ? MOD : SETUP;
      MOD:         nxt = k0 < K_W'(cfg_ncb) ? RUN : MOD;
      RUN:         nxt = abort ? IDLE : hs && out_last ? DRAIN : RUN;
      default:     nxt = IDLE;
    endcase
  end
  always_comb begin
    ready = idle;
    done = state == DRAIN || err_q;
    err = err_q;
    rd_en = state == RUN && room && !in_flight;
    rd_addr = ptr;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      cfg_rv <= '0;
      cfg_r <= '0;
      cfg_ncb <= '0;
      cfg_e <= '0;
      cfg_q <= '0;
      rem <= '0;
      n <= '0;
      k0 <= '0;
      ptr <= '0;
      null_cnt <= '0;
      cnt <= '0;
      in_flight <= 1'b0;
      err_q <= 1'b0;
    end else begin
      err_q <= (go && !cfg_good) || abort;
      in_flight <= rd_en;
      if (go) begin
        cfg_rv <= rv_idx;
        cfg_r <= R;
        cfg_ncb <= Ncb;
        cfg_e <= E;
        cfg_q <= qm;
        rem <= Ncb;
        n <= '0;
        cnt <= '0;
        null_cnt <= '0;
      end
      if (state == SETUP) begin
        rem <= last_rem ? '0 : ADDR_W'(K_W'(rem) - step);
        n <= n + 1'b1;
        if (last_rem) k0 <= k0_calc;
      end
      if (state == MOD) begin
        if (k0 >= K_W'(cfg_ncb)) k0 <= k0 - K_W'(cfg_ncb);
        else ptr <= ADDR_W'(k0);
      end
      if (rd_en) ptr <= ptr == cfg_ncb - 1'b1 ? '0 : ptr + 1'b1;
      if (is_null) null_cnt <= null_cnt + 1'b1;
      else if (got_bit) null_cnt <= '0;
      if (hs) cnt <= cnt + E_W'(cfg_q);
    end
  rm_beat_packer #(.BEAT_W(BEAT_W)) u_pack (
    .clk(clk),
    .rst(rst),
    .clr(state != RUN),
    .qm(cfg_q),
    .in_flight(in_flight),
    .bit_valid(state == RUN && got_bit),
    .bit_in(rd_data[0]),
    .out_ready(out_ready),
    .out_valid(out_valid),
    .out_bits(out_bits),
    .room(room)
  );
endmodule

// File: tb/tb_rm_bit_selector.sv
// tb_rm_bit_selector: directed vectors with a beat/done scoreboard and a decoupled monitor
module tb_rm_bit_selector;
  typedef struct packed {logic [7:0] bits; logic last;} beat_t;
  logic clk = 0, rst = 0, start = 0, out_ready = 1;
  logic [1:0] rv_idx = 0;
  logic [6:0] R = 2;
  logic [12:0] Kw = 192, Ncb = 192;
  logic [15:0] E = 0;
  logic [3:0] qm = 0;
  logic rd_en, out_valid, out_last, done, err, ready;
  logic [12:0] rd_addr;
  logic [1:0] rd_data = 0;
  logic [7:0] out_bits;
  logic [1:0] mem [0:255];
  beat_t exp_q[$];
  bit exp_done[$];
  logic [7:0] got_bits[$];
  int checks = 0, errors = 0, beats = 0, rd_cnt = 0, wraps = 0;
  bit prev_last_hs = 0, de;
  beat_t bx;
  logic [12:0] last_addr = 0;

  rm_bit_selector dut (
    .clk(clk), .rst(rst), .start(start), .ready(ready), .rv_idx(rv_idx), .R(R), .Kw(Kw),
    .Ncb(Ncb), .E(E), .qm(qm), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_bits(out_bits), .out_last(out_last),
    .done(done), .err(err)
  );

  always #5 clk = ~clk;
  always @(posedge clk) rd_data <= mem[rd_addr[7:0]];

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", nm, act, exp);
    end
  endtask

  always @(negedge clk)
    if (!rst) prev_last_hs = 0;
    else begin
      if (done) begin
        chk("done_expected", longint'(exp_done.size() != 0), 1);
        if (exp_done.size() != 0) begin
          de = exp_done.pop_front();
          chk("done_err", err, de);
          if (!de) chk("done_after_last", prev_last_hs, 1);
        end
      end
      if (rd_en) begin
        rd_cnt++;
        if (rd_addr == 0 && last_addr == 191) wraps++;
        last_addr = rd_addr;
      end
      if (out_valid && out_ready) begin
        chk("beat_expected", longint'(exp_q.size() != 0), 1);
        if (exp_q.size() != 0) begin
          bx = exp_q.pop_front();
          chk("beat_bits", out_bits, bx.bits);
          chk("beat_last", out_last, bx.last);
        end
        beats++;
        got_bits.push_back(out_bits);
      end
      prev_last_hs = out_valid && out_ready && out_last;
    end

  function automatic int calc_k0(input int r, input int ncb, input int rv);
    int n;
    n = (ncb + 8 * r - 1) / (8 * r);
    return (2 * r * (n * rv + 1)) % ncb;
  endfunction

  task automatic model(input int rv, input int ncb, input int e, input int q);
    int p, got, nulls, fill;
    logic [7:0] b;
    beat_t t;
    p = calc_k0(2, ncb, rv);
    got = 0; nulls = 0; fill = 0; b = 0;
    while (got < e) begin
      if (mem[p][1]) begin
        nulls++;
        if (nulls == ncb) begin
          exp_done.push_back(1);
          return;
        end
      end else begin
        nulls = 0;
        b[fill] = mem[p][0];
        fill++;
        got++;
        if (fill == q) begin
          t.bits = b;
          t.last = got == e;
          exp_q.push_back(t);
          b = 0;
          fill = 0;
        end
      end
      p = (p + 1) % ncb;
    end
    exp_done.push_back(0);
  endtask

  task automatic launch(input int rv, input int ncb, input int e, input int q);
    @(posedge clk); #1;
    rv_idx = 2'(rv); Ncb = 13'(ncb); E = 16'(e); qm = 4'(q); start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic first_addr(input int exp);
    bit f = 0;
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      if (rd_en) begin f = 1; break; end
    end
    chk("first_rd_seen", f, 1);
    if (f) chk("first_rd_addr", rd_addr, exp);
  endtask

  task automatic wait_done();
    bit f = 0;
    for (int k = 0; k < 5000; k++) begin
      @(negedge clk);
      if (done) begin f = 1; break; end
    end
    chk("done_seen", f, 1);
  endtask

  task automatic wait_beats(input int target);
    bit f = 0;
    for (int k = 0; k < 1000; k++) begin
      @(negedge clk);
      if (beats >= target) begin f = 1; break; end
    end
    chk("beats_reached", f, 1);
  endtask

  initial begin
    int b0, r0, w0;
    bit f;
    for (int i = 0; i < 256; i++) mem[i] = {1'b0, (i % 3) != 1};
    @(negedge clk);
    chk("rst_ready", ready, 1);
    chk("rst_rd_en", rd_en, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_done", done, 0);
    @(posedge clk); #1 rst = 1;

    b0 = beats; model(0, 192, 24, 2); launch(0, 192, 24, 2);
    first_addr(4); wait_done();
    chk("rv0_beats", beats - b0, 12);
    chk("rv0_first_beat", got_bits[b0], 8'h02);

    b0 = beats; model(2, 192, 24, 2); launch(2, 192, 24, 2);
    first_addr(100); wait_done();
    chk("rv2_first_beat", got_bits[b0], 8'h02);

    b0 = beats; w0 = wraps; model(3, 192, 96, 4); launch(3, 192, 96, 4);
    first_addr(148); wait_done();
    chk("rv3_beats", beats - b0, 24);
    chk("rv3_wrap", wraps - w0, 1);
    chk("rv3_first_beat", got_bits[b0], 8'h06);

    mem[4] = 2'b10; mem[5] = 2'b11;
    b0 = beats; model(0, 192, 24, 2); launch(0, 192, 24, 2);
    first_addr(4); wait_done();
    chk("null_first_beat", got_bits[b0], 8'h01);
    chk("null_beats", beats - b0, 12);
    mem[4] = 2'b00; mem[5] = 2'b01;

    b0 = beats; model(0, 192, 24, 2); launch(0, 192, 24, 2);
    wait_beats(b0 + 2);
    @(posedge clk); #1 out_ready = 0;
    f = 0;
    for (int k = 0; k < 50; k++) begin
      @(negedge clk);
      if (out_valid) begin f = 1; break; end
    end
    chk("stall_valid_seen", f, 1);
    for (int i = 0; i < 5; i++) begin
      if (i > 0) @(negedge clk);
      chk("stall_bits", out_bits, 8'h03);
      chk("stall_valid", out_valid, 1);
      chk("stall_no_rd", rd_en, 0);
    end
    @(posedge clk); #1 out_ready = 1;
    wait_done();
    chk("stall_beats", beats - b0, 12);

    exp_done.push_back(1); r0 = rd_cnt;
    launch(0, 192, 10, 3);
    @(negedge clk);
    chk("bad_qm_done", done, 1);
    chk("bad_qm_err", err, 1);
    repeat (5) @(negedge clk);
    chk("bad_qm_no_rd", rd_cnt - r0, 0);
    chk("bad_qm_ready", ready, 1);

    exp_done.push_back(1); r0 = rd_cnt;
    launch(0, 200, 24, 2);
    @(negedge clk);
    chk("bad_ncb_done", done, 1);
    chk("bad_ncb_err", err, 1);
    repeat (5) @(negedge clk);
    chk("bad_ncb_no_rd", rd_cnt - r0, 0);

    for (int i = 0; i < 256; i++) mem[i] = 2'b10;
    b0 = beats; r0 = rd_cnt; model(0, 192, 24, 2); launch(0, 192, 24, 2);
    wait_done();
    chk("null_lap_reads", rd_cnt - r0, 192);
    chk("null_lap_beats", beats - b0, 0);
    for (int i = 0; i < 256; i++) mem[i] = {1'b0, (i % 3) != 1};

    b0 = beats; model(0, 192, 24, 2); launch(0, 192, 24, 2);
    wait_beats(b0 + 3);
    @(posedge clk); #3 rst = 0;
    #1;
    chk("async_rst_ready", ready, 1);
    chk("async_rst_rd_en", rd_en, 0);
    chk("async_rst_rd_addr", rd_addr, 0);
    chk("async_rst_valid", out_valid, 0);
    chk("async_rst_bits", out_bits, 0);
    chk("async_rst_last", out_last, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_err", err, 0);
    exp_q.delete();
    exp_done.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1;

    b0 = beats; model(0, 192, 24, 2); launch(0, 192, 24, 2);
    first_addr(4); wait_done();
    chk("post_rst_beats", beats - b0, 12);
    chk("post_rst_first_beat", got_bits[b0], 8'h02);
    repeat (3) @(negedge clk);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/rm_bit_selector.md
# rm_bit_selector

Parametrised bit-selection stage for the rate matcher. It replaces the fixed 1-bit selector path after the circular buffer. It reads the interleaved circular buffer as {null flag, bit} entries and computes the redundancy-version start k0 for a limited buffer size Ncb. It wraps modulo Ncb, discards dummy entries, and emits exactly E selected bits packed into qm-bit beats over a valid/ready handshake for the modulation mapper.

## Interface
- `R_W`, default 7: width of subblock row count R.
- `ADDR_W`, default 13: circular-buffer address and Kw/Ncb width.
- `E_W`, default 16: width of E and output-bit counters.
- `BEAT_W`, default 8: maximum bits per output beat (largest Qm).
- `clk` in 1: rate-matcher clock.
- `rst` in 1: reset, asynchronous, active-low.
- `start` in 1: begin a code block; sampled only while `ready`=1.
- `ready` out 1: idle, accepting `start`.
- `rv_idx` in 2: redundancy version 0..3.
- `R` in R_W: subblock interleaver rows (C fixed at 32).
- `Kw` in ADDR_W: circular buffer length (3·32·R).
- `Ncb` in ADDR_W: soft-buffer limit, 1..Kw.
- `E` in E_W: number of output bits.
- `qm` in 4: bits per beat, 1..BEAT_W.
- `rd_en` out 1: buffer read strobe.
- `rd_addr` out ADDR_W: buffer read address.
- `rd_data` in 2: [1]=null flag, [0]=bit; valid the cycle after `rd_en`.
- `out_valid` out 1: beat available.
- `out_ready` in 1: sink accepts beat.
- `out_bits` out BEAT_W: packed beat; bit 0 is the first-selected bit; bits ≥qm are 0.
- `out_last` out 1: final beat of the block, qualified by `out_valid`.
- `done` out 1: one-cycle pulse at block end, normal or error.
- `err` out 1: one-cycle pulse, coincident with `done`, on an error end.

## Operation
- States: IDLE, SETUP, MOD, RUN, DRAIN.
- IDLE: `ready`=1.
  - `start` latches all config inputs.
  - Config check: 1≤qm≤BEAT_W, E≠0, E%qm=0, 1≤Ncb≤Kw, R≠0.
  - If the check fails: pulse `done`+`err` the next cycle and stay in IDLE. No `rd_en` is issued.
- SETUP: compute n = ceil(Ncb/(8R)).
  - rem←Ncb; each cycle, while rem>0: rem←rem−8R (saturating at 0) and n←n+1.
  - Then k0 = 2R·(n·rv_idx+1).
- MOD: while k0≥Ncb, k0←k0−Ncb, one subtraction per cycle. Then ptr←k0.
- RUN:
  - Issue `rd_en` with `rd_addr`=ptr only when (packed + in_flight) < qm and no beat is held. Max one read in flight.
  - ptr increments and wraps Ncb−1→0.
  - Returned entry with null=1: discarded, not counted, and the consecutive-null counter increments.
  - Returned entry with null=0: the bit is shifted into position `packed`, and the null counter clears.
  - When packed=qm: present the beat with `out_valid`=1. `out_last`=1 when the emitted-bit count after this beat equals E.
- Beat held: `out_bits`/`out_last` stay stable until `out_ready`. No reads are issued while held.
- After the last beat is accepted: DRAIN one cycle, pulse `done`, return to IDLE.
- Null counter reaching Ncb (a full lap with no data): abort, pulse `done`+`err`, drop the partial beat, return to IDLE.
- `start` outside IDLE is ignored.
- Reset, including mid-block: immediately IDLE. `ready`=1; all other outputs 0; counters, ptr and k0 are 0.
- Arithmetic:
  - Widths of n and k0 are sized for n≤ceil(2^ADDR_W/8) and product ≤2·R_max·(3n+1).
  - k0 is reduced before use, so `rd_addr` is always <Ncb.

## Timing
- `start` at edge t: SETUP occupies n cycles, MOD occupies m≥0 cycles, and the first `rd_en` is at t+1+n+m.
- Read latency 1 cycle; one bit per 2 cycles while unstalled.
- First `out_valid` no earlier than 2·qm cycles after the first `rd_en` (no nulls).
- `out_valid` rises only on a clock edge and never drops without `out_ready`.
- `done` asserts the cycle after the final handshake. `ready` returns the same cycle.

## Structure
- Package `rm_pkg`:
  - State enum.
  - Null-flag bit index constant.
  - C=32 constant.
  - Config-check function.
- Sub-module `rm_beat_packer`:
  - Shift-in of bits, `packed` count, held beat and `out_valid`/`out_ready`.
  - Reports room available to the read-issue logic.

## Test plan
- R=2, Kw=Ncb=192, rv=0, E=24, qm=2, no nulls → n=12, k0=4; first `rd_addr`=4; 12 beats; `out_last` on the 12th; `done` one cycle later.
- Same config with rv=2 and rv=3 → first `rd_addr`=100 and 148. With rv=3, E=96, qm=4: addresses wrap 191→0; 24 beats; data matches the model.
- Entries 4,5 null, rv=0, qm=2 → first beat carries entries 6 (bit0) and 7 (bit1). Null entries are not counted toward E.
- `out_ready` held low 5 cycles on the 3rd beat → `out_bits` stable, `rd_en`=0 throughout; resumes with no lost or duplicated bit.
- Bad configs:
  - qm=3, E=10 → `done`+`err` the next cycle; zero `rd_en`.
  - Ncb=200 > Kw=192 → same response.
- Buffer all null, Ncb=192 → `err` after 192 reads. Also: reset asserted mid-RUN → all outputs 0 and `ready`=1 asynchronously; a new `start` runs cleanly.
